// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// opcode constants, instruction classes, pc_src and trap_cause encodings.
package multicycle_ctrl_pkg;

    // Opcode field values (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Sequencer states; the encoding is visible on state_dbg
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    // Instruction class latched in DECODE
    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_RTYPE   = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_J       = 3'd5,
        CLS_ADDI    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } class_e;

    // PC source mux encodings
    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Trap cause encodings
    localparam logic [1:0] CAUSE_NONE        = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'd1;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_opcode_decode.sv
// Combinational opcode classifier shared by the multi-cycle sequencer and
// future pipelined control: opcode -> instruction class plus illegal flag.
module ctrl_opcode_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode_i,
    output class_e           class_o,
    output logic             illegal_o
);

    // Map the opcode onto its class; anything unrecognised is illegal
    always_comb begin
        class_o   = CLS_ILLEGAL;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_W'(OP_RTYPE): class_o = CLS_RTYPE;
            OPC_W'(OP_LW):    class_o = CLS_LW;
            OPC_W'(OP_SW):    class_o = CLS_SW;
            OPC_W'(OP_BEQ):   class_o = CLS_BEQ;
            OPC_W'(OP_J):     class_o = CLS_J;
            OPC_W'(OP_ADDI):  class_o = CLS_ADDI;
            default: begin
                class_o   = CLS_ILLEGAL;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the single MIPS datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready and traps
// on illegal opcodes or memory timeouts. Define CTRL_PERF_CNT_EN to add the
// retired_cnt / stall_cnt performance counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 8,
    parameter int OPC_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             alu_branch,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_dbg
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]      retired_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    // Last wait count value at which a still-pending access times out
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e     state_q, state_d;
    class_e     class_q, class_d;
    logic [7:0] wait_q, wait_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;

    class_e     dec_class;
    logic       dec_illegal;

    ctrl_opcode_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode_i  (opcode),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            class_q <= CLS_NONE;
            wait_q  <= 8'd0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Next-state, class latch, wait counter and trap capture
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        wait_d  = wait_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                class_d = dec_class;
                if (dec_illegal) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_class == CLS_J) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (class_q)
                    CLS_RTYPE, CLS_ADDI: state_d = S_WB;
                    CLS_LW, CLS_SW: begin
                        state_d = S_MEM;
                        wait_d  = 8'd0;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // A completion on the final wait cycle takes priority over the timeout
                if (mem_ready) begin
                    state_d = (class_q == CLS_LW) ? S_WB : S_FETCH;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB:   state_d = S_FETCH;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Moore strobe/select decode; everything forced low while rst is asserted
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PCSRC_SEQ;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: ir_write = 1'b1;
                S_DECODE: begin
                    // Class is not latched yet, so jumps use the live decode
                    if (dec_class == CLS_J) begin
                        pc_write = 1'b1;
                        pc_src   = PCSRC_JUMP;
                    end
                end
                S_EXEC: begin
                    case (class_q)
                        CLS_RTYPE: reg_dst = 1'b1;
                        CLS_ADDI, CLS_LW, CLS_SW: alu_src = 1'b1;
                        CLS_BEQ: begin
                            pc_write = 1'b1;
                            pc_src   = alu_branch ? PCSRC_BRANCH : PCSRC_SEQ;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    alu_src   = 1'b1;
                    mem_read  = (class_q == CLS_LW);
                    mem_write = (class_q == CLS_SW);
                    // Stores retire in the cycle the memory acknowledges
                    pc_write  = (class_q == CLS_SW) && mem_ready;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    mem_to_reg = (class_q == CLS_LW);
                    reg_dst    = (class_q == CLS_RTYPE);
                end
                default: ;
            endcase
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state_dbg  = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    // Retired count wraps; stall count saturates at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            retired_q <= retired_q + 32'(pc_write);
            if ((state_q == S_MEM) && !mem_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl. Expected per-cycle
// output traces are generated per instruction from the sequencing rules.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int MAXW = 8;
    localparam int K_OTHER = 0;
    localparam int K_DEC   = 1;
    localparam int K_BEQ   = 2;
    localparam int K_MEM   = 3;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       alu_branch;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       trap;
    logic [1:0] trap_cause;
    logic [2:0] state_dbg;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] ret_m;
    logic [31:0] stall_m;
`endif

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(
        .MEM_WAIT_MAX (MAXW),
        .OPC_W        (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .alu_branch (alu_branch),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_dbg  (state_dbg)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    logic [15:0] obs;
    assign obs = {pc_write, pc_src, ir_write, reg_dst, alu_src, mem_to_reg,
                  reg_write, mem_read, mem_write, trap, trap_cause, state_dbg};

    typedef struct {
        logic [15:0] exp;
        int          kind;
        logic        rdy;
    } cyc_t;

    cyc_t tr[$];
    bit   trapped;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] v(input logic pcw, input logic [1:0] pcs, input logic irw,
                                      input logic rd, input logic as, input logic m2r,
                                      input logic rw, input logic mr, input logic mw,
                                      input logic trp, input logic [1:0] tc, input logic [2:0] st);
        return {pcw, pcs, irw, rd, as, m2r, rw, mr, mw, trp, tc, st};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    task automatic push(input logic [15:0] e, input int k, input logic r);
        cyc_t c;
        c.exp  = e;
        c.kind = k;
        c.rdy  = r;
        tr.push_back(c);
    endtask

    // Expected trace from FETCH up to the cycle before the next FETCH
    task automatic build(input logic [5:0] op, input logic br, input int w);
        bit is_lw, is_sw;
        tr.delete();
        trapped = 0;
        push(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), K_OTHER, 1'b0);
        if (op == OP_J) begin
            push(v(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1), K_DEC, 1'b0);
            return;
        end
        push(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1), K_DEC, 1'b0);
        if (!is_legal(op)) begin
            repeat (3) push(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 3'd7), K_OTHER, 1'b0);
            trapped = 1;
            return;
        end
        if (op == OP_BEQ) begin
            push(v(1, br ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2), K_BEQ, 1'b0);
            return;
        end
        if (op == OP_RTYPE) push(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'd2), K_OTHER, 1'b0);
        else                push(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd2), K_OTHER, 1'b0);
        is_lw = (op == OP_LW);
        is_sw = (op == OP_SW);
        if (is_lw || is_sw) begin
            for (int i = 0; i < ((w < MAXW) ? w : MAXW); i++)
                push(v(0, 0, 0, 0, 1, 0, 0, is_lw, is_sw, 0, 0, 3'd3), K_MEM, 1'b0);
            if (w >= MAXW) begin
                repeat (3) push(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd7), K_OTHER, 1'b0);
                trapped = 1;
                return;
            end
            push(v(is_sw, 0, 0, 0, 1, 0, 0, is_lw, is_sw, 0, 0, 3'd3), K_MEM, 1'b1);
            if (is_sw) return;
        end
        push(v(1, 0, 0, op == OP_RTYPE, 0, is_lw, 1, 0, 0, 0, 0, 3'd4), K_OTHER, 1'b0);
    endtask

    // Entered and left at posedge+1 of a FETCH cycle (or mid-trace when cut >= 0)
    task automatic run(input string tag, input logic [5:0] op, input logic br,
                       input int w, input int cut);
        build(op, br, w);
        for (int i = 0; i < tr.size(); i++) begin
            if (cut >= 0 && i == cut) break;
            opcode     = (tr[i].kind == K_DEC) ? op : 6'($urandom);
            alu_branch = (tr[i].kind == K_BEQ) ? br : 1'($urandom);
            mem_ready  = (tr[i].kind == K_MEM) ? tr[i].rdy : 1'($urandom);
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, i), 32'(obs), 32'(tr[i].exp));
`ifdef CTRL_PERF_CNT_EN
            if (i == 0) begin
                check({tag, "_retired"}, retired_cnt, ret_m);
                check({tag, "_stall"}, stall_cnt, stall_m);
            end
            ret_m = ret_m + 32'(tr[i].exp[15]);
            if (tr[i].kind == K_MEM && !tr[i].rdy && stall_m != 32'hFFFF_FFFF)
                stall_m = stall_m + 32'd1;
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst        = 1'b0;
        opcode     = 6'($urandom);
        alu_branch = 1'($urandom);
        mem_ready  = 1'($urandom);
        #1;
        check({tag, "_async"}, 32'(obs), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'($urandom);
        #1;
        check({tag, "_held"}, 32'(obs), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check({tag, "_cnt0"}, retired_cnt | stall_cnt, 32'd0);
        ret_m   = 32'd0;
        stall_m = 32'd0;
`endif
        rst = 1'b1;
    endtask

    initial begin
        logic [5:0] op;
        logic       br;
        int         w, r;
        rst        = 1'b0;
        opcode     = 6'd0;
        alu_branch = 1'b0;
        mem_ready  = 1'b0;
`ifdef CTRL_PERF_CNT_EN
        ret_m   = 32'd0;
        stall_m = 32'd0;
`endif
        @(posedge clk);
        #1;
        do_reset("rst0");

        run("rtype", OP_RTYPE, 1'b0, 0, -1);
        run("lw3", OP_LW, 1'b0, 3, -1);
        run("beq1", OP_BEQ, 1'b1, 0, -1);
        run("beq0", OP_BEQ, 1'b0, 0, -1);
        run("j", OP_J, 1'b0, 0, -1);
        run("addi", OP_ADDI, 1'b0, 0, -1);
        run("sw_last", OP_SW, 1'b0, MAXW - 1, -1);
        run("lw_last", OP_LW, 1'b0, MAXW - 1, -1);
        run("sw_to", OP_SW, 1'b0, MAXW, -1);
        do_reset("rst_to");
        run("ill", 6'b111111, 1'b0, 0, -1);
        do_reset("rst_ill");
        run("lw_cut", OP_LW, 1'b0, 5, 5);
        do_reset("rst_mem");

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 13);
            case (r)
                0, 1:   op = OP_RTYPE;
                2, 3:   op = OP_LW;
                4, 5:   op = OP_SW;
                6, 7:   op = OP_BEQ;
                8, 9:   op = OP_J;
                10, 11: op = OP_ADDI;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            r = $urandom_range(0, 9);
            w = (r < 7) ? (r % 4) : ((r == 7) ? MAXW - 1 : ((r == 8) ? MAXW : 0));
            br = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                run($sformatf("rnd%0d_cut", n), op, br, w, $urandom_range(1, 4));
                do_reset($sformatf("rnd%0d_rst", n));
            end else begin
                run($sformatf("rnd%0d", n), op, br, w, -1);
                if (trapped) do_reset($sformatf("rnd%0d_rst", n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
